// File: rtl/pll_reconfig_seq.sv
// Queues CRTC PLL register writes and, on commit, replays them to the PLL
// reconfiguration Avalon-MM port, issues the start write, then waits for relock.
module pll_reconfig_seq #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned LOCK_TIMEOUT = 2000000,
  parameter logic [5:0]  START_ADDR   = 6'd2,
  parameter logic [5:0]  MODE_ADDR    = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  pll_addr,
  input  logic [31:0] pll_value,
  input  logic        pll_write,
  output logic        pll_busy,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        overflow,
  output logic        lock_timeout,
  input  logic        error_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned EW = 38;

  typedef enum logic [2:0] {INIT, IDLE, DRAIN, START, WAIT_LOCK} state_t;

  state_t          state, state_n;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_n;
  logic            commit_pending, commit_n;
  logic [TW-1:0]   timer, timer_n;
  logic            mgmt_write_n;
  logic [5:0]      addr_n;
  logic [31:0]     data_n;
  logic            overflow_n, lock_timeout_n, busy_n;
  logic            xfer_done, is_commit, push_req, full, empty;
  logic            push, pop, start_done, timed_out;

  // A transfer is accepted on any edge where write is up and waitrequest is low
  assign xfer_done  = mgmt_write & ~mgmt_waitrequest;
  assign is_commit  = pll_write & (pll_addr == START_ADDR);
  assign push_req   = pll_write & ~is_commit;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pop        = (state == DRAIN) & xfer_done;
  assign push       = push_req & (~full | pop);
  assign start_done = (state == START) & xfer_done;
  assign timed_out  = (state == WAIT_LOCK) & ~pll_locked &
                      (timer == TW'(LOCK_TIMEOUT - 1));

  assign count_n        = count + CW'(push) - CW'(pop);
  assign commit_n       = is_commit ? 1'b1 : (start_done ? 1'b0 : commit_pending);
  assign overflow_n     = error_clr ? 1'b0 : (overflow | (push_req & ~push));
  assign lock_timeout_n = error_clr ? 1'b0 : (lock_timeout | timed_out);
  assign busy_n         = (state_n != IDLE) | (count_n != '0) | commit_n;

  // Next-state and next Avalon request; the request only moves once accepted
  always_comb begin
    state_n      = state;
    mgmt_write_n = mgmt_write;
    addr_n       = mgmt_address;
    data_n       = mgmt_writedata;
    timer_n      = timer;
    case (state)
      INIT: begin
        if (xfer_done) begin
          mgmt_write_n = 1'b0;
          state_n      = IDLE;
        end else if (!mgmt_write) begin
          mgmt_write_n = 1'b1;
          addr_n       = MODE_ADDR;
          data_n       = '0;
        end
      end
      IDLE: begin
        if (commit_pending) state_n = DRAIN;
      end
      DRAIN: begin
        if (xfer_done) begin
          mgmt_write_n = 1'b0;
        end else if (!mgmt_write) begin
          mgmt_write_n = 1'b1;
          if (empty) begin
            state_n = START;
            addr_n  = START_ADDR;
            data_n  = '0;
          end else begin
            {addr_n, data_n} = mem[rd_ptr];
          end
        end
      end
      START: begin
        if (xfer_done) begin
          mgmt_write_n = 1'b0;
          timer_n      = '0;
          state_n      = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        timer_n = timer + TW'(1);
        if (pll_locked || timed_out) state_n = IDLE;
      end
      default: begin
        state_n      = INIT;
        mgmt_write_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= INIT;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      timer          <= '0;
      commit_pending <= 1'b0;
      overflow       <= 1'b0;
      lock_timeout   <= 1'b0;
      pll_busy       <= 1'b1;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      state          <= state_n;
      mgmt_write     <= mgmt_write_n;
      mgmt_address   <= addr_n;
      mgmt_writedata <= data_n;
      timer          <= timer_n;
      commit_pending <= commit_n;
      overflow       <= overflow_n;
      lock_timeout   <= lock_timeout_n;
      pll_busy       <= busy_n;
      count          <= count_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Entry storage carries no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pll_addr, pll_value};
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: init write, commit drain, stalls,
// overflow, relock timeout and reset mid-drain.
module tb_pll_reconfig_seq;

  localparam int unsigned LT = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  pll_addr = '0;
  logic [31:0] pll_value = '0;
  logic        pll_write = 1'b0;
  logic        pll_busy;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b1;
  logic        overflow;
  logic        lock_timeout;
  logic        error_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int viol = 0;
  int wait_cycles = 0;
  int hold_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [38:0] prev_out = '0;
  logic [37:0] acc_q[$];
  int          acc_cyc[$];

  pll_reconfig_seq #(.DEPTH(16), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset),
    .pll_addr(pll_addr), .pll_value(pll_value), .pll_write(pll_write),
    .pll_busy(pll_busy),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked),
    .overflow(overflow), .lock_timeout(lock_timeout), .error_clr(error_clr)
  );

  always #5 clk = ~clk;

  // Record accepted transfers and any request change during a stall
  always @(posedge clk) begin
    cyc++;
    if (prev_stall && ({mgmt_write, mgmt_address, mgmt_writedata} !== prev_out)) viol++;
    prev_stall = mgmt_write & mgmt_waitrequest;
    prev_out   = {mgmt_write, mgmt_address, mgmt_writedata};
    if (mgmt_write === 1'b1 && mgmt_waitrequest === 1'b0) begin
      acc_q.push_back({mgmt_address, mgmt_writedata});
      acc_cyc.push_back(cyc);
    end
  end

  // Slave model: stall each request for wait_cycles cycles
  always @(negedge clk) begin
    if (mgmt_write === 1'b1 && hold_cnt < wait_cycles) begin
      mgmt_waitrequest = 1'b1;
      hold_cnt++;
    end else begin
      mgmt_waitrequest = 1'b0;
      hold_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_acc(input int n, input int limit, input string tag);
    int k = 0;
    while (acc_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(acc_q.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int k = 0;
    while (pll_busy !== 1'b0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(pll_busy), 64'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] v);
    pll_write = 1'b1;
    pll_addr  = a;
    pll_value = v;
    @(negedge clk);
    pll_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int t0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(pll_busy), 64'd1);
    check("rst_write", 64'(mgmt_write), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_lto", 64'(lock_timeout), 64'd0);
    acc_q.delete(); acc_cyc.delete();
    reset = 1'b0;

    // INIT mode write, then idle
    repeat (3) @(negedge clk);
    check("init_busy", 64'(pll_busy), 64'd0);
    repeat (10) @(negedge clk);
    check("init_count", 64'(acc_q.size()), 64'd1);
    check("init_xfer", 64'(acc_q[0]), 64'({6'd0, 32'd0}));

    // Basic drain with zero wait states, relock after 10 cycles
    acc_q.delete(); acc_cyc.delete();
    wr(6'd3, 32'h11); wr(6'd4, 32'h22); wr(6'd5, 32'h33);
    repeat (5) @(negedge clk);
    check("queued_busy", 64'(pll_busy), 64'd1);
    check("queued_no_xfer", 64'(acc_q.size()), 64'd0);
    pll_locked = 1'b0;
    wr(6'd2, 32'hDEAD_BEEF);
    wait_acc(4, 200, "t2_wait");
    repeat (9) @(negedge clk);
    check("t2_busy_wait", 64'(pll_busy), 64'd1);
    pll_locked = 1'b1;
    @(negedge clk);
    check("t2_busy_after_lock", 64'(pll_busy), 64'd0);
    check("t2_count", 64'(acc_q.size()), 64'd4);
    check("t2_x0", 64'(acc_q[0]), 64'({6'd3, 32'h11}));
    check("t2_x1", 64'(acc_q[1]), 64'({6'd4, 32'h22}));
    check("t2_x2", 64'(acc_q[2]), 64'({6'd5, 32'h33}));
    check("t2_start", 64'(acc_q[3]), 64'({6'd2, 32'd0}));

    // Same drain with 5 waitrequest cycles per transfer
    acc_q.delete(); acc_cyc.delete();
    wait_cycles = 5;
    wr(6'd3, 32'hA1); wr(6'd4, 32'hB2); wr(6'd5, 32'hC3); wr(6'd2, 32'h0);
    wait_acc(4, 400, "t3_wait");
    wait_idle(200, "t3_idle");
    check("t3_count", 64'(acc_q.size()), 64'd4);
    check("t3_x0", 64'(acc_q[0]), 64'({6'd3, 32'hA1}));
    check("t3_x1", 64'(acc_q[1]), 64'({6'd4, 32'hB2}));
    check("t3_x2", 64'(acc_q[2]), 64'({6'd5, 32'hC3}));
    check("t3_start", 64'(acc_q[3]), 64'({6'd2, 32'd0}));
    check("t3_stall_len", 64'((acc_cyc[1] - acc_cyc[0]) >= 6), 64'd1);
    check("t3_stable", 64'(viol), 64'd0);
    wait_cycles = 0;

    // Overflow: 17 writes into 16 entries
    acc_q.delete(); acc_cyc.delete();
    for (int i = 0; i < 16; i++) wr(6'd8, 32'(100 + i));
    check("t4_ovf_at_full", 64'(overflow), 64'd0);
    wr(6'd8, 32'd116);
    check("t4_ovf_set", 64'(overflow), 64'd1);
    error_clr = 1'b1;
    @(negedge clk);
    error_clr = 1'b0;
    check("t4_ovf_clr", 64'(overflow), 64'd0);
    wr(6'd2, 32'd0);
    wait_acc(17, 400, "t4_wait");
    wait_idle(200, "t4_idle");
    check("t4_count", 64'(acc_q.size()), 64'd17);
    check("t4_first", 64'(acc_q[0]), 64'({6'd8, 32'd100}));
    check("t4_16th", 64'(acc_q[15]), 64'({6'd8, 32'd115}));
    check("t4_start", 64'(acc_q[16]), 64'({6'd2, 32'd0}));

    // Relock timeout
    acc_q.delete(); acc_cyc.delete();
    pll_locked = 1'b0;
    wr(6'd2, 32'd0);
    wait_acc(1, 100, "t5_wait");
    check("t5_start", 64'(acc_q[0]), 64'({6'd2, 32'd0}));
    k = 0;
    while (lock_timeout !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    t0 = (acc_cyc.size() > 0) ? acc_cyc[0] : 0;
    check("t5_lto", 64'(lock_timeout), 64'd1);
    check("t5_lto_delay", 64'(cyc - t0), 64'(LT));
    check("t5_busy", 64'(pll_busy), 64'd0);
    error_clr = 1'b1;
    @(negedge clk);
    error_clr = 1'b0;
    check("t5_lto_clr", 64'(lock_timeout), 64'd0);
    pll_locked = 1'b1;

    // Reset after the first of three drained entries
    acc_q.delete(); acc_cyc.delete();
    wr(6'd9, 32'd1); wr(6'd10, 32'd2); wr(6'd11, 32'd3); wr(6'd2, 32'd0);
    wait_acc(1, 100, "t6_wait");
    reset = 1'b1;
    @(negedge clk);
    check("t6_write_off", 64'(mgmt_write), 64'd0);
    check("t6_busy_rst", 64'(pll_busy), 64'd1);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("t6_count", 64'(acc_q.size()), 64'd2);
    check("t6_first", 64'(acc_q[0]), 64'({6'd9, 32'd1}));
    check("t6_init", 64'(acc_q[1]), 64'({6'd0, 32'd0}));
    check("t6_busy", 64'(pll_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sits directly downstream of the video timing CRTC's PLL register interface.
- Accepts single-cycle PLL register write pulses (address + 32-bit value) and queues them in a small FIFO.
- On a commit request, drains the queue to the Altera PLL reconfiguration Avalon-MM management port, issues the start write, then waits for PLL relock.
- Reports busy back to the CRTC (readable there) and keeps sticky error flags.

Parameters:
DEPTH, 16, FIFO entries (power of 2, ≥2); each entry is {addr[5:0], value[31:0]}.
LOCK_TIMEOUT, 2000000, clk cycles allowed between start-write completion and pll_locked high.
START_ADDR, 6'd2, PLL reconfig start register address; a write here is a commit, not queued.
MODE_ADDR, 6'd0, PLL reconfig mode register; 0 is written to it once after reset (waitrequest mode).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
pll_addr  in  6  register address from CRTC
pll_value  in  32  register value from CRTC
pll_write  in  1  one-cycle write strobe
pll_busy  out  1  high while not IDLE, FIFO non-empty, or commit pending
mgmt_address  out  6  Avalon-MM address to PLL reconfig
mgmt_writedata  out  32  Avalon-MM write data
mgmt_write  out  1  Avalon-MM write
mgmt_waitrequest  in  1  Avalon-MM waitrequest
pll_locked  in  1  PLL lock (assumed pre-synchronised to clk)
overflow  out  1  sticky: write dropped because FIFO full
lock_timeout  out  1  sticky: relock not seen within LOCK_TIMEOUT
error_clr  in  1  clears overflow and lock_timeout

Behaviour:
- Reset (sync): FIFO empty; commit_pending=0; state=INIT; mgmt_write=0; mgmt_address=0; mgmt_writedata=0; overflow=0; lock_timeout=0; timer=0. pll_busy=1 while in INIT.
- Ingest on every pll_write (independent of state):
  - addr==START_ADDR: commit_pending<=1; value ignored.
  - otherwise: push if not full; if full, drop and set overflow.
  - Pop and push in the same cycle are both allowed at full.
- States:
  - INIT: drive MODE_ADDR, data 0, mgmt_write=1; hold while waitrequest=1; first cycle with waitrequest=0 completes -> IDLE.
  - IDLE: if commit_pending -> DRAIN. Queued writes without a commit stay in the FIFO indefinitely.
  - DRAIN: if FIFO empty -> START. Else present head entry with mgmt_write=1, held stable while waitrequest=1. On the waitrequest=0 cycle, pop; the next entry is presented no earlier than the following cycle (mgmt_write may stay high back-to-back).
  - START: write START_ADDR, data 0; on completion clear commit_pending (unless a new commit arrives that same cycle; the new one wins and stays 1), timer=0 -> WAIT_LOCK.
  - WAIT_LOCK: timer increments each cycle. pll_locked=1 -> IDLE. timer==LOCK_TIMEOUT-1 without lock -> set lock_timeout -> IDLE.
- Entries pushed during DRAIN are drained in the same pass. Entries pushed after DRAIN has exited wait for the next commit.
- Avalon rules: mgmt_address, mgmt_writedata and mgmt_write must not change while mgmt_write=1 and waitrequest=1. mgmt_write=0 outside INIT/DRAIN/START.
- pll_busy = (state!=IDLE) | ~empty | commit_pending; registered output, updated the cycle after the causing event.
- error_clr has priority over a same-cycle set.
- Reset mid-transaction aborts immediately: outputs return to reset values, FIFO contents are discarded, and INIT reruns.
- Timer width is clog2(LOCK_TIMEOUT)+1.

Test Plan:
- Reset, waitrequest=0 -> one mgmt_write to addr 0 data 0, then pll_busy falls within 3 cycles, all other mgmt_write=0.
- Push (3,0x11),(4,0x22),(5,0x33), then pll_write addr 2; waitrequest=0; pll_locked drops and rises 10 cycles after start -> mgmt sequence 3/0x11, 4/0x22, 5/0x33, 2/0; pll_busy low the cycle after lock.
- Same as above with waitrequest held 5 cycles per transfer -> address/data stable throughout; exactly 4 accepted writes in order.
- Push 17 non-commit writes with DEPTH=16 -> overflow=1, 16th entry retained, 17th absent from drain; error_clr -> overflow=0.
- Commit with pll_locked held 0, LOCK_TIMEOUT=100 -> lock_timeout=1 exactly 100 cycles after start completes; state IDLE, pll_busy=0.
- Assert reset during DRAIN after 1 of 3 entries written -> mgmt_write=0 the next cycle, INIT write reissued, no remaining entries emitted, no start write.
